// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared CORE encodings: memory-channel states and phase indices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  localparam logic [1:0] CH_IDLE = 2'd0;
  localparam logic [1:0] CH_REQ  = 2'd1;
  localparam logic [1:0] CH_DONE = 2'd2;
  localparam logic [1:0] CH_ERR  = 2'd3;

  localparam int PH_IDX_FETCH        = 0;
  localparam int PH_IDX_DECODE       = 1;
  localparam int PH_IDX_EXECUTE      = 2;
  localparam int PH_IDX_MEMORYACCESS = 3;
  localparam int PH_IDX_WRITEBACK    = 4;

  localparam logic [4:0] PH_FETCH        = 5'b00001;
  localparam logic [4:0] PH_DECODE       = 5'b00010;
  localparam logic [4:0] PH_EXECUTE      = 5'b00100;
  localparam logic [4:0] PH_MEMORYACCESS = 5'b01000;
  localparam logic [4:0] PH_WRITEBACK    = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/stall_req_channel.sv
// ============================================================================
// Module      : stall_req_channel
// Description : One req/ack memory channel that stalls its phase until done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_req_channel
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic phase,
  input  logic ack,
  output logic req,
  output logic stall,
  output logic timeout
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             w_in_req;
  logic             w_start;
  logic             w_timeout;

  assign w_in_req  = (r_state == CH_REQ);
  assign w_start   = (r_state == CH_IDLE) & start;
  // ack on the last allowed cycle still completes the access
  assign w_timeout = w_in_req & phase & ~ack & (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CH_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        CH_IDLE: begin
          if (start) begin
            r_state <= CH_REQ;
            r_cnt   <= '0;
            r_req   <= 1'b1;
          end
        end
        CH_REQ: begin
          if (!phase) begin
            r_state <= CH_IDLE;
            r_req   <= 1'b0;
          end else if (ack) begin
            r_state <= CH_DONE;
            r_req   <= 1'b0;
          end else if (r_cnt == C_CNT_LAST) begin
            r_state <= CH_ERR;
            r_req   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        CH_DONE, CH_ERR: begin
          if (!phase) r_state <= CH_IDLE;
        end
        default: begin
          r_state <= CH_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign req     = r_req;
  assign stall   = ~rst & (w_start | (w_in_req & phase & ~ack & ~w_timeout));
  assign timeout = ~rst & w_timeout;

endmodule

`default_nettype wire

// File: rtl/stall_controller.sv
// ============================================================================
// Module      : stall_controller
// Description : Converts sequencer phases into memory handshakes and stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_controller
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic phase_fetch,
  input  logic phase_decode,
  input  logic phase_execute,
  input  logic phase_memoryaccess,
  input  logic phase_writeback,
  input  logic dmem_access,
  input  logic exec_busy,
  input  logic imem_ack,
  input  logic dmem_ack,
  input  logic error_clr,
  output logic imem_req,
  output logic dmem_req,
  output logic stall_fetch,
  output logic stall_decode,
  output logic stall_execute,
  output logic stall_memoryaccess,
  output logic stall_writeback,
  output logic bus_error
);

  logic r_fetch_d;
  logic r_mem_d;
  logic r_bus_error;
  logic w_fetch_entry;
  logic w_mem_entry;
  logic w_imem_timeout;
  logic w_dmem_timeout;
  logic w_unused;

  // decode and writeback never stall; their phase inputs are informational
  assign w_unused = &{1'b0, phase_decode, phase_writeback};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_d <= 1'b0;
      r_mem_d   <= 1'b0;
    end else begin
      r_fetch_d <= phase_fetch;
      r_mem_d   <= phase_memoryaccess;
    end
  end

  assign w_fetch_entry = phase_fetch & ~r_fetch_d;
  assign w_mem_entry   = phase_memoryaccess & ~r_mem_d;

  stall_req_channel #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_imem (
    .clk    (clk),
    .rst    (rst),
    .start  (w_fetch_entry),
    .phase  (phase_fetch),
    .ack    (imem_ack),
    .req    (imem_req),
    .stall  (stall_fetch),
    .timeout(w_imem_timeout)
  );

  stall_req_channel #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_dmem (
    .clk    (clk),
    .rst    (rst),
    .start  (w_mem_entry & dmem_access),
    .phase  (phase_memoryaccess),
    .ack    (dmem_ack),
    .req    (dmem_req),
    .stall  (stall_memoryaccess),
    .timeout(w_dmem_timeout)
  );

  // a fresh timeout outranks a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_error <= 1'b0;
    end else if (w_imem_timeout | w_dmem_timeout) begin
      r_bus_error <= 1'b1;
    end else if (error_clr) begin
      r_bus_error <= 1'b0;
    end
  end

  assign bus_error       = r_bus_error;
  assign stall_execute   = ~rst & phase_execute & exec_busy;
  assign stall_decode    = 1'b0;
  assign stall_writeback = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_stall_controller.sv
// ============================================================================
// Module      : tb_stall_controller
// Description : Directed self-checking bench for stall_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stall_controller;

  logic clk;
  logic rst;
  logic phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback;
  logic dmem_access, exec_busy, imem_ack, dmem_ack, error_clr;
  logic imem_req, dmem_req, stall_fetch, stall_decode, stall_execute;
  logic stall_memoryaccess, stall_writeback, bus_error;

  int n_tests;
  int n_fail;

  stall_controller #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .phase_fetch       (phase_fetch),
    .phase_decode      (phase_decode),
    .phase_execute     (phase_execute),
    .phase_memoryaccess(phase_memoryaccess),
    .phase_writeback   (phase_writeback),
    .dmem_access       (dmem_access),
    .exec_busy         (exec_busy),
    .imem_ack          (imem_ack),
    .dmem_ack          (dmem_ack),
    .error_clr         (error_clr),
    .imem_req          (imem_req),
    .dmem_req          (dmem_req),
    .stall_fetch       (stall_fetch),
    .stall_decode      (stall_decode),
    .stall_execute     (stall_execute),
    .stall_memoryaccess(stall_memoryaccess),
    .stall_writeback   (stall_writeback),
    .bus_error         (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    phase_fetch = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({imem_req, dmem_req, stall_fetch, stall_decode, stall_execute,
         stall_memoryaccess, stall_writeback, bus_error} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {imem_req, dmem_req, stall_fetch, stall_decode, stall_execute,
                stall_memoryaccess, stall_writeback, bus_error});
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({stall_fetch, imem_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release_entry: stall_fetch,imem_req=%b expected 10", {stall_fetch, imem_req});
    end
    @(negedge clk);
    n_tests++;
    if ({stall_fetch, imem_req} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_req: stall_fetch,imem_req=%b expected 11", {stall_fetch, imem_req});
    end
    imem_ack = 1'b1;
    #1;
    n_tests++;
    if (stall_fetch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack_unstall: stall_fetch=%b expected 0", stall_fetch);
    end
    tick;
    imem_ack = 1'b0;
    phase_fetch = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done_req: imem_req=%b expected 0", imem_req);
    end
    tick;
  endtask

  task automatic test_fetch_min_latency;
    int cycles;
    logic [7:0] seq;
    cycles = 0;
    seq = '0;
    phase_fetch = 1'b1;
    imem_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seq = {seq[6:0], stall_fetch};
      cycles++;
      if (!stall_fetch) break;
      tick;
    end
    n_tests++;
    if (cycles !== 2 || seq[1:0] !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_min_latency: cycles=%0d stalls=%b expected cycles=2 stalls=10", cycles, seq[1:0]);
    end
    tick;
    phase_fetch = 1'b0;
    imem_ack = 1'b0;
    phase_decode = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({stall_decode, imem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL decode_phase: stall_decode,imem_req=%b expected 00", {stall_decode, imem_req});
    end
    tick;
    phase_decode = 1'b0;
    tick;
  endtask

  task automatic test_dmem_wait;
    int cycles, stall_hi, req_hi;
    cycles = 0; stall_hi = 0; req_hi = 0;
    phase_memoryaccess = 1'b1;
    dmem_access = 1'b1;
    for (int k = 0; k < 12; k++) begin
      dmem_ack = (k >= 4);
      @(negedge clk);
      cycles++;
      if (stall_memoryaccess) stall_hi++;
      if (dmem_req) req_hi++;
      if (!stall_memoryaccess) break;
      tick;
    end
    n_tests++;
    if (cycles !== 5 || stall_hi !== 4 || req_hi !== 4) begin
      n_fail++;
      $display("FAIL dmem_wait: cycles=%0d stall_hi=%0d req_hi=%0d expected 5 4 4", cycles, stall_hi, req_hi);
    end
    tick;
    phase_memoryaccess = 1'b0;
    dmem_ack = 1'b0;
    dmem_access = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dmem_req, bus_error} !== 2'b00) begin
      n_fail++;
      $display("FAIL dmem_ack_on_last_cycle: dmem_req,bus_error=%b expected 00", {dmem_req, bus_error});
    end
    tick;
  endtask

  task automatic test_no_dmem;
    phase_memoryaccess = 1'b1;
    dmem_access = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({stall_memoryaccess, dmem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL no_dmem_entry: stall,dmem_req=%b expected 00", {stall_memoryaccess, dmem_req});
    end
    tick;
    phase_memoryaccess = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL no_dmem_req: dmem_req=%b expected 0", dmem_req);
    end
    tick;
  endtask

  task automatic test_timeout;
    int cycles, stall_hi;
    for (int pass = 0; pass < 2; pass++) begin
      cycles = 0; stall_hi = 0;
      phase_fetch = 1'b1;
      imem_ack = 1'b0;
      error_clr = (pass == 1);
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        cycles++;
        if (stall_fetch) stall_hi++;
        if (!stall_fetch) break;
        tick;
      end
      n_tests++;
      if (cycles !== 5 || stall_hi !== 4 || bus_error !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_stall_p%0d: cycles=%0d stall_hi=%0d bus_error=%b expected 5 4 0",
                 pass, cycles, stall_hi, bus_error);
      end
      tick;
      @(negedge clk);
      n_tests++;
      if ({bus_error, imem_req, stall_fetch} !== 3'b100) begin
        n_fail++;
        $display("FAIL timeout_flag_p%0d: bus_error,imem_req,stall=%b expected 100",
                 pass, {bus_error, imem_req, stall_fetch});
      end
      error_clr = 1'b0;
      phase_fetch = 1'b0;
      tick;
      tick;
      @(negedge clk);
      n_tests++;
      if (bus_error !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_sticky_p%0d: bus_error=%b expected 1", pass, bus_error);
      end
      error_clr = 1'b1;
      tick;
      error_clr = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus_error !== 1'b0) begin
        n_fail++;
        $display("FAIL error_clr_p%0d: bus_error=%b expected 0", pass, bus_error);
      end
      tick;
    end
  endtask

  task automatic test_exec;
    logic [7:0] pattern;
    int stall_hi;
    pattern = 8'b0011_1110;
    stall_hi = 0;
    phase_execute = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exec_busy = pattern[k];
      @(negedge clk);
      if (stall_execute) stall_hi++;
      n_tests++;
      if (stall_execute !== pattern[k]) begin
        n_fail++;
        $display("FAIL exec_stall_cycle%0d: stall_execute=%b expected %b", k, stall_execute, pattern[k]);
      end
      tick;
    end
    n_tests++;
    if (stall_hi !== 5) begin
      n_fail++;
      $display("FAIL exec_stall_count: %0d cycles expected 5", stall_hi);
    end
    phase_execute = 1'b0;
    exec_busy = 1'b1;
    @(negedge clk);
    n_tests++;
    if (stall_execute !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_outside_phase: stall_execute=%b expected 0", stall_execute);
    end
    exec_busy = 1'b0;
    tick;
  endtask

  task automatic test_abort_and_async_reset;
    phase_fetch = 1'b1;
    imem_ack = 1'b0;
    tick;
    phase_fetch = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({imem_req, stall_fetch} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_in_req: imem_req,stall=%b expected 10", {imem_req, stall_fetch});
    end
    tick;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_req_drop: imem_req=%b expected 0", imem_req);
    end
    tick;
    phase_fetch = 1'b1;
    @(negedge clk);
    n_tests++;
    if (stall_fetch !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reentry: stall_fetch=%b expected 1", stall_fetch);
    end
    tick;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: imem_req=%b expected 1", imem_req);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({imem_req, stall_fetch} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset_mid_req: imem_req,stall=%b expected 00", {imem_req, stall_fetch});
    end
    phase_fetch = 1'b0;
    tick;
    rst = 1'b0;
    tick;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    phase_fetch = 1'b0; phase_decode = 1'b0; phase_execute = 1'b0;
    phase_memoryaccess = 1'b0; phase_writeback = 1'b0;
    dmem_access = 1'b0; exec_busy = 1'b0; imem_ack = 1'b0;
    dmem_ack = 1'b0; error_clr = 1'b0;
    tick;
    test_reset;
    test_fetch_min_latency;
    test_dmem_wait;
    test_no_dmem;
    test_timeout;
    test_exec;
    test_abort_and_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
